// File: rtl/ddr_rw_sched_pkg.sv
// Shared DDR scheduler definitions: FSM state encoding and the beat geometry.
package ddr_rw_sched_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARB     = 3'd1,
        WR_REQ  = 3'd2,
        WR_BUSY = 3'd3,
        RD_REQ  = 3'd4,
        RD_BUSY = 3'd5
    } sched_state_t;

    // One 128-bit FIFO beat carries eight 16-bit words.
    localparam int unsigned BEAT_WORDS = 8;

endpackage

// File: rtl/ddr_addr_gen.sv
// Region offset pointer: advances one burst per completed transfer, wraps at the
// region end with a frame pulse, and supports a deferred rewind request.
module ddr_addr_gen #(
    parameter logic [27:0] BASE       = 28'd0,
    parameter logic [10:0] BURST_LEN  = 11'd256,
    parameter logic [27:0] REGION_LEN = 28'd921600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    input  logic        clr,
    input  logic        clr_allow,
    output logic [27:0] adrs,
    output logic        frame_done
);

    logic [27:0] off_reg;
    logic        pend_reg;
    logic [28:0] sum_next;
    logic        wrap_next;
    logic        clr_any;

    assign sum_next  = {1'b0, off_reg} + {18'd0, BURST_LEN};
    assign wrap_next = (sum_next >= {1'b0, REGION_LEN});
    assign clr_any   = pend_reg | clr;
    assign adrs      = BASE + off_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            off_reg    <= 28'd0;
            pend_reg   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (advance) begin
                // A rewind pending at completion time overrides both advance and wrap.
                pend_reg <= 1'b0;
                if (clr_any) begin
                    off_reg <= 28'd0;
                end else if (wrap_next) begin
                    off_reg    <= 28'd0;
                    frame_done <= 1'b1;
                end else begin
                    off_reg <= sum_next[27:0];
                end
            end else if (clr_any) begin
                if (clr_allow) begin
                    off_reg  <= 28'd0;
                    pend_reg <= 1'b0;
                end else begin
                    pend_reg <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ddr_rw_sched.sv
// Read/write burst scheduler for a single-port DDR AXI master: fair alternation
// between the write FIFO drain and the read FIFO refill, one request at a time.
module ddr_rw_sched
    import ddr_rw_sched_pkg::*;
#(
    parameter logic [10:0] BURST_LEN   = 11'd256,
    parameter logic [27:0] WR_BASE     = 28'd0,
    parameter logic [27:0] RD_BASE     = 28'd0,
    parameter logic [27:0] REGION_LEN  = 28'd921600,
    parameter logic [9:0]  RFIFO_DEPTH = 10'd512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_done,
    input  logic        rd_en,
    input  logic        wr_ptr_clr,
    input  logic        rd_ptr_clr,
    input  logic [9:0]  wfifo_rd_cnt,
    input  logic [9:0]  rfifo_wr_cnt,
    output logic        wr_start,
    output logic [27:0] wr_adrs,
    output logic [10:0] wr_len,
    input  logic        wr_ready,
    input  logic        wr_done,
    output logic        rd_start,
    output logic [27:0] rd_adrs,
    output logic [10:0] rd_len,
    input  logic        rd_ready,
    input  logic        rd_done,
    output logic        wr_frame_done,
    output logic        rd_frame_done
);

    localparam logic [10:0] BURST_BEATS = 11'(BURST_LEN / BEAT_WORDS);

    sched_state_t state_reg;
    logic         last_wr_reg;
    logic         wr_elig;
    logic         rd_elig;
    logic [10:0]  rd_space;

    // Index 0 is the write pointer, index 1 the read pointer.
    logic [1:0]   gen_advance;
    logic [1:0]   gen_clr;
    logic [1:0]   gen_clr_allow;
    logic [1:0]   gen_frame;
    logic [27:0]  gen_adrs [2];

    assign rd_space = {1'b0, RFIFO_DEPTH} - {1'b0, rfifo_wr_cnt};
    assign wr_elig  = ({1'b0, wfifo_rd_cnt} >= BURST_BEATS);
    assign rd_elig  = rd_en && (rfifo_wr_cnt <= RFIFO_DEPTH) && (rd_space >= BURST_BEATS);

    assign gen_advance[0]   = (state_reg == WR_BUSY) && wr_done;
    assign gen_advance[1]   = (state_reg == RD_BUSY) && rd_done;
    assign gen_clr[0]       = wr_ptr_clr;
    assign gen_clr[1]       = rd_ptr_clr;
    assign gen_clr_allow[0] = (state_reg != WR_REQ) && (state_reg != WR_BUSY);
    assign gen_clr_allow[1] = (state_reg != RD_REQ) && (state_reg != RD_BUSY);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_addr
            ddr_addr_gen #(
                .BASE       ((gi == 0) ? WR_BASE : RD_BASE),
                .BURST_LEN  (BURST_LEN),
                .REGION_LEN (REGION_LEN)
            ) u_addr_gen (
                .clk        (clk),
                .rst        (rst),
                .advance    (gen_advance[gi]),
                .clr        (gen_clr[gi]),
                .clr_allow  (gen_clr_allow[gi]),
                .adrs       (gen_adrs[gi]),
                .frame_done (gen_frame[gi])
            );
        end
    endgenerate

    assign wr_frame_done = gen_frame[0];
    assign rd_frame_done = gen_frame[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            last_wr_reg <= 1'b0;
            wr_start    <= 1'b0;
            rd_start    <= 1'b0;
            wr_adrs     <= WR_BASE;
            rd_adrs     <= RD_BASE;
            wr_len      <= BURST_LEN;
            rd_len      <= BURST_LEN;
        end else begin
            wr_start <= 1'b0;
            rd_start <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (init_done) state_reg <= ARB;
                end
                ARB: begin
                    // Write wins unless read is also eligible and write went last.
                    if (wr_elig && (!rd_elig || !last_wr_reg)) begin
                        state_reg   <= WR_REQ;
                        last_wr_reg <= 1'b1;
                    end else if (rd_elig) begin
                        state_reg   <= RD_REQ;
                        last_wr_reg <= 1'b0;
                    end
                end
                WR_REQ: begin
                    if (wr_ready) begin
                        wr_start  <= 1'b1;
                        wr_adrs   <= gen_adrs[0];
                        wr_len    <= BURST_LEN;
                        state_reg <= WR_BUSY;
                    end
                end
                WR_BUSY: begin
                    if (wr_done) state_reg <= ARB;
                end
                RD_REQ: begin
                    if (rd_ready) begin
                        rd_start  <= 1'b1;
                        rd_adrs   <= gen_adrs[1];
                        rd_len    <= BURST_LEN;
                        state_reg <= RD_BUSY;
                    end
                end
                RD_BUSY: begin
                    if (rd_done) state_reg <= ARB;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_rw_sched.sv
// Directed bench for ddr_rw_sched with a 512-word region so wraps happen quickly.
module tb_ddr_rw_sched;

    localparam logic [27:0] WB = 28'h0010000;
    localparam logic [27:0] RB = 28'h0020000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_done = 1'b0;
    logic        rd_en = 1'b1;
    logic        wr_ptr_clr = 1'b0;
    logic        rd_ptr_clr = 1'b0;
    logic [9:0]  wfifo_rd_cnt = 10'd100;
    logic [9:0]  rfifo_wr_cnt = 10'd0;
    logic        wr_start;
    logic [27:0] wr_adrs;
    logic [10:0] wr_len;
    logic        wr_ready = 1'b1;
    logic        wr_done = 1'b0;
    logic        rd_start;
    logic [27:0] rd_adrs;
    logic [10:0] rd_len;
    logic        rd_ready = 1'b1;
    logic        rd_done = 1'b0;
    logic        wr_frame_done;
    logic        rd_frame_done;

    int total_cnt = 0;
    int bad_cnt   = 0;

    ddr_rw_sched #(
        .BURST_LEN   (11'd256),
        .WR_BASE     (WB),
        .RD_BASE     (RB),
        .REGION_LEN  (28'd512),
        .RFIFO_DEPTH (10'd512)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .init_done     (init_done),
        .rd_en         (rd_en),
        .wr_ptr_clr    (wr_ptr_clr),
        .rd_ptr_clr    (rd_ptr_clr),
        .wfifo_rd_cnt  (wfifo_rd_cnt),
        .rfifo_wr_cnt  (rfifo_wr_cnt),
        .wr_start      (wr_start),
        .wr_adrs       (wr_adrs),
        .wr_len        (wr_len),
        .wr_ready      (wr_ready),
        .wr_done       (wr_done),
        .rd_start      (rd_start),
        .rd_adrs       (rd_adrs),
        .rd_len        (rd_len),
        .rd_ready      (rd_ready),
        .rd_done       (rd_done),
        .wr_frame_done (wr_frame_done),
        .rd_frame_done (rd_frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic no_start(input int cycles, input string tag);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (wr_start || rd_start) seen++;
        end
        chk(tag, seen, 0);
        $display("idle %s: %0d cycles, starts=%0d", tag, cycles, seen);
    endtask

    // One full transfer: wait for the grant, check it, hold, complete, check frame pulse.
    task automatic xfer(input string tag, input bit is_wr, input logic [27:0] exp_adrs,
                        input bit exp_frame, input bit do_clr, input bit stray,
                        input logic [9:0] wf_after, input logic [9:0] rf_after);
        int n = 0;
        logic [27:0] adrs_seen;
        while (!(wr_start || rd_start) && n < 40) begin
            tick();
            n++;
        end
        adrs_seen = is_wr ? wr_adrs : rd_adrs;
        $display("xfer %s %s adrs=%h after %0d cycles", tag, is_wr ? "W" : "R", adrs_seen, n);
        chk({tag, "_start"}, is_wr ? wr_start : rd_start, 1);
        chk({tag, "_other"}, is_wr ? rd_start : wr_start, 0);
        chk({tag, "_adrs"}, adrs_seen, exp_adrs);
        chk({tag, "_len"}, is_wr ? wr_len : rd_len, 11'd256);
        wfifo_rd_cnt = wf_after;
        rfifo_wr_cnt = rf_after;
        tick();
        chk({tag, "_pulse1"}, is_wr ? wr_start : rd_start, 0);
        if (do_clr) begin
            if (is_wr) wr_ptr_clr = 1'b1; else rd_ptr_clr = 1'b1;
        end
        if (stray) begin
            if (is_wr) rd_done = 1'b1; else wr_done = 1'b1;
        end
        tick();
        wr_ptr_clr = 1'b0;
        rd_ptr_clr = 1'b0;
        rd_done    = 1'b0;
        wr_done    = 1'b0;
        tick();
        chk({tag, "_hold"}, is_wr ? wr_adrs : rd_adrs, exp_adrs);
        if (is_wr) wr_done = 1'b1; else rd_done = 1'b1;
        tick();
        wr_done = 1'b0;
        rd_done = 1'b0;
        chk({tag, "_frame"}, is_wr ? wr_frame_done : rd_frame_done, exp_frame);
        chk({tag, "_oframe"}, is_wr ? rd_frame_done : wr_frame_done, 0);
        tick();
        chk({tag, "_frame_end"}, is_wr ? wr_frame_done : rd_frame_done, 0);
    endtask

    initial begin
        int n;
        tick();
        tick();
        chk("rst_wr_start", wr_start, 0);
        chk("rst_rd_start", rd_start, 0);
        chk("rst_wr_adrs", wr_adrs, WB);
        chk("rst_rd_adrs", rd_adrs, RB);
        chk("rst_wr_len", wr_len, 11'd256);
        chk("rst_rd_len", rd_len, 11'd256);
        chk("rst_frames", {wr_frame_done, rd_frame_done}, 0);
        rst = 1'b0;

        no_start(10, "no_init");
        init_done = 1'b1;

        // Both sides eligible: W, R, W(wrap), R(wrap), W.
        xfer("w0",  1, WB,          0, 0, 0, 10'd100, 10'd0);
        xfer("r0",  0, RB,          0, 0, 0, 10'd100, 10'd0);
        xfer("w1",  1, WB + 28'd256, 1, 0, 0, 10'd100, 10'd0);
        xfer("r1",  0, RB + 28'd256, 1, 0, 0, 10'd100, 10'd0);
        xfer("w2",  1, WB,          0, 0, 0, 10'd100, 10'd490);
        // Rewind during busy at offset 256 collides with a wrap; stray rd_done ignored.
        xfer("wclr", 1, WB + 28'd256, 0, 1, 1, 10'd0, 10'd490);

        no_start(8, "rfull490");
        rfifo_wr_cnt = 10'd481;
        no_start(8, "rfull481");
        rfifo_wr_cnt = 10'd480;
        xfer("r480", 0, RB,         0, 0, 0, 10'd100, 10'd490);

        // Rewind at offset 0 would otherwise leave the pointer at 256.
        xfer("wclr0", 1, WB,        0, 1, 0, 10'd100, 10'd490);
        xfer("w3",    1, WB,        0, 0, 0, 10'd100, 10'd490);

        // Reset in the middle of a write at offset 256.
        n = 0;
        while (!wr_start && n < 40) begin
            tick();
            n++;
        end
        chk("rb_start", wr_start, 1);
        chk("rb_adrs", wr_adrs, WB + 28'd256);
        $display("xfer rb W adrs=%h (reset pending)", wr_adrs);
        wfifo_rd_cnt = 10'd0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rb_rst_adrs", wr_adrs, WB);
        chk("rb_rst_radrs", rd_adrs, RB);
        chk("rb_rst_start", wr_start, 0);
        tick();
        tick();
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        chk("rb_stale_frame", wr_frame_done, 0);
        no_start(5, "rb_idle");
        wfifo_rd_cnt = 10'd100;
        rfifo_wr_cnt = 10'd0;
        xfer("rb_w", 1, WB, 0, 0, 0, 10'd100, 10'd0);
        xfer("rb_r", 0, RB, 0, 0, 0, 10'd100, 10'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
